led_pattern_gen: RTL and testbench

- Parametrised, multi-channel successor to the single-LED blinker.
- Drives CHANNELS LED outputs from one clock domain; each channel has its own divider, mode (off/on/blink/PWM) and duty, reprogrammable at runtime through a valid/ready config port.
- Outputs are gated by a PLL-lock qualifier, so LEDs stay dark until the feeding PLL has been stably locked.
- Sits directly behind a PLL output in chip-level designs, replacing per-LED blinker instances.

---
 rtl/led_pattern_gen.sv | 169 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator. Each channel runs off/on/blink/PWM from
// its own prescaler, and all outputs stay dark until the PLL lock has been stable.
module led_pattern_gen #(
  parameter int                   CHANNELS    = 4,
  parameter int                   DIV_WIDTH   = 24,
  parameter int                   PWM_WIDTH   = 8,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(24'd4999999),
  parameter int                   LOCK_CYCLES = 1024,
  localparam int                  CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [1:0]           cfg_mode,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [PWM_WIDTH-1:0] cfg_duty,
  output logic [CHANNELS-1:0]  led
);

  localparam int                   LOCK_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0]    LOCK_MAX = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [PWM_WIDTH-1:0] DUTY_RST = PWM_WIDTH'(1) << (PWM_WIDTH - 1);

  typedef enum logic {
    ST_WAIT_LOCK,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  state_e                 state_q, state_d;
  logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic                   cfg_ready_q;
  logic [CHANNELS-1:0]    led_q, led_d;

  mode_e                  mode_q  [CHANNELS];
  mode_e                  mode_d  [CHANNELS];
  logic [DIV_WIDTH-1:0]   div_q   [CHANNELS];
  logic [DIV_WIDTH-1:0]   div_d   [CHANNELS];
  logic [PWM_WIDTH-1:0]   duty_q  [CHANNELS];
  logic [PWM_WIDTH-1:0]   duty_d  [CHANNELS];
  logic [DIV_WIDTH-1:0]   pre_q   [CHANNELS];
  logic [DIV_WIDTH-1:0]   pre_d   [CHANNELS];
  logic [CHANNELS-1:0]    tog_q, tog_d;
  logic [PWM_WIDTH-1:0]   phase_q [CHANNELS];
  logic [PWM_WIDTH-1:0]   phase_d [CHANNELS];

  logic                   wr_en;
  logic                   run_ok;
  logic [31:0]            chan_ext;

  assign wr_en     = cfg_valid & cfg_ready_q;
  assign run_ok    = (state_q == ST_RUN) & locked;
  assign chan_ext  = 32'(cfg_chan);
  assign cfg_ready = cfg_ready_q;
  assign led       = led_q;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    led_d      = '0;
    tog_d      = tog_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (!locked) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_MAX) begin
          state_d    = ST_RUN;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked) begin
          state_d    = ST_WAIT_LOCK;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_WAIT_LOCK;
        lock_cnt_d = '0;
      end
    endcase

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      mode_d[i]  = mode_q[i];
      div_d[i]   = div_q[i];
      duty_d[i]  = duty_q[i];
      pre_d[i]   = pre_q[i];
      phase_d[i] = phase_q[i];

      if (run_ok) begin
        if (pre_q[i] == '0) begin
          pre_d[i]   = div_q[i];
          tog_d[i]   = ~tog_q[i];
          phase_d[i] = phase_q[i] + PWM_WIDTH'(1);
        end else begin
          pre_d[i]   = pre_q[i] - DIV_WIDTH'(1);
        end
      end else begin
        pre_d[i]   = div_q[i];
        tog_d[i]   = 1'b0;
        phase_d[i] = '0;
      end

      // A config write overrides any tick landing on the same edge.
      if (wr_en && (chan_ext == i)) begin
        mode_d[i]  = mode_e'(cfg_mode);
        div_d[i]   = cfg_div;
        duty_d[i]  = cfg_duty;
        pre_d[i]   = cfg_div;
        tog_d[i]   = 1'b0;
        phase_d[i] = '0;
      end

      // Output is computed from next-state so it lands together with the state.
      if (state_d == ST_RUN) begin
        case (mode_d[i])
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = tog_d[i];
          MODE_PWM:   led_d[i] = (phase_d[i] < duty_d[i]);
          default:    led_d[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_WAIT_LOCK;
      lock_cnt_q  <= '0;
      cfg_ready_q <= 1'b0;
      led_q       <= '0;
      tog_q       <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= MODE_BLINK;
        div_q[i]   <= DEFAULT_DIV;
        duty_q[i]  <= DUTY_RST;
        pre_q[i]   <= DEFAULT_DIV;
        phase_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      cfg_ready_q <= 1'b1;
      led_q       <= led_d;
      tog_q       <= tog_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= mode_d[i];
        div_q[i]   <= div_d[i];
        duty_q[i]  <= duty_d[i];
        pre_q[i]   <= pre_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random config/lock traffic,
// checked every cycle against a tick-count model of each channel.
module tb_led_pattern_gen;

  localparam int              CH   = 4;
  localparam int              DW   = 24;
  localparam int              PW   = 8;
  localparam int              LK   = 8;
  localparam logic [DW-1:0]   DDIV = 24'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          locked = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, cfg_ready3;
  logic [1:0]    cfg_chan = '0;
  logic [1:0]    cfg_mode = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [PW-1:0] cfg_duty = '0;
  logic [3:0]    led;
  logic [2:0]    led3;

  int tests = 0;
  int fails = 0;

  led_pattern_gen #(
    .CHANNELS(CH), .DIV_WIDTH(DW), .PWM_WIDTH(PW), .DEFAULT_DIV(DDIV), .LOCK_CYCLES(LK)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_duty(cfg_duty), .led(led)
  );

  // Three-channel instance on the same bus: writes to channel 3 are out of range for it.
  led_pattern_gen #(
    .CHANNELS(3), .DIV_WIDTH(DW), .PWM_WIDTH(PW), .DEFAULT_DIV(DDIV), .LOCK_CYCLES(LK)
  ) dut3 (
    .clk(clk), .rst(rst), .locked(locked), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_duty(cfg_duty), .led(led3)
  );

  always #5 clk = ~clk;

  // Model: each channel is described by edges elapsed in RUN since its last restart.
  bit     m_run;
  int     m_lk;
  bit     m_rdy;
  int     m_mode [CH];
  int     m_div  [CH];
  int     m_duty [CH];
  longint m_n    [CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_lk  = 0;
    m_rdy = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_mode[i] = 2;
      m_div[i]  = int'(DDIV);
      m_duty[i] = 1 << (PW - 1);
      m_n[i]    = 0;
    end
  endtask

  task automatic model_step();
    bit wr;
    wr = cfg_valid && m_rdy;
    if (!m_run) begin
      if (!locked) m_lk = 0;
      else if (m_lk == LK - 1) begin
        m_run = 1'b1;
        m_lk  = 0;
        for (int i = 0; i < CH; i++) m_n[i] = 0;
      end else m_lk++;
    end else if (!locked) begin
      m_run = 1'b0;
      m_lk  = 0;
    end else begin
      for (int i = 0; i < CH; i++) m_n[i]++;
    end
    if (wr) begin
      m_mode[cfg_chan] = int'(cfg_mode);
      m_div[cfg_chan]  = int'(cfg_div);
      m_duty[cfg_chan] = int'(cfg_duty);
      m_n[cfg_chan]    = 0;
    end
    m_rdy = 1'b1;
  endtask

  function automatic logic [3:0] model_led();
    logic [3:0] r;
    longint     ticks;
    r = '0;
    if (m_run) begin
      for (int i = 0; i < CH; i++) begin
        ticks = m_n[i] / longint'(m_div[i] + 1);
        case (m_mode[i])
          0: r[i] = 1'b0;
          1: r[i] = 1'b1;
          2: r[i] = ticks[0];
          default: r[i] = (ticks % (64'sd1 <<< PW)) < longint'(m_duty[i]);
        endcase
      end
    end
    return r;
  endfunction

  task automatic check_outputs();
    logic [3:0] e;
    e = model_led();
    check_eq("led", 32'(led), 32'(e));
    check_eq("led3", 32'(led3), 32'(e[2:0]));
    check_eq("ready", 32'(cfg_ready), 32'(m_rdy));
    check_eq("ready3", 32'(cfg_ready3), 32'(m_rdy));
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic write(input int ch, input int mode, input int dv, input int duty);
    cfg_chan  = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_div   = DW'(dv);
    cfg_duty  = PW'(duty);
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int  pwm_hi;
    bit  aligned;
    model_reset();
    locked = 1'b1;
    @(negedge clk);
    check_outputs();
    cycle();
    cycle();

    // Lock qualification, then all channels blinking in phase.
    rst = 1'b1;
    repeat (24) cycle();

    // One-cycle lock drop.
    locked = 1'b0;
    cycle();
    locked = 1'b1;
    repeat (20) cycle();

    // PWM at duty 64 on a per-cycle tick: 64 of every 256 cycles high.
    write(2, 3, 0, 64);
    pwm_hi = int'(led[2]);
    for (int k = 1; k < 256; k++) begin
      cycle();
      pwm_hi += int'(led[2]);
    end
    check_eq("pwm_duty_count", 32'(pwm_hi), 32'd64);

    // Back-to-back writes, and a write that only the 3-channel instance ignores.
    write(1, 0, 3, 0);
    write(3, 1, 3, 0);
    repeat (4) cycle();
    write(3, 2, 1, 0);
    repeat (6) cycle();

    // Reprogram ch0 exactly on its tick edge.
    write(0, 2, 3, 0);
    aligned = 1'b0;
    for (int k = 0; k < 20 && !aligned; k++) begin
      if (m_run && (m_n[0] % longint'(m_div[0] + 1)) == longint'(m_div[0])) aligned = 1'b1;
      else cycle();
    end
    check_eq("tick_align_found", 32'(aligned), 32'd1);
    write(0, 2, 9, 0);
    repeat (32) cycle();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      locked = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_chan  = 2'($urandom_range(0, 3));
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_div   = DW'($urandom_range(0, 6));
        case ($urandom_range(0, 3))
          0:       cfg_duty = '0;
          1:       cfg_duty = '1;
          default: cfg_duty = PW'($urandom);
        endcase
        cfg_valid = 1'b1;
      end else cfg_valid = 1'b0;
      cycle();
    end
    cfg_valid = 1'b0;
    locked    = 1'b1;
    repeat (12) cycle();

    // Asynchronous reset in the middle of PWM.
    write(2, 3, 0, 64);
    repeat (10) cycle();
    @(posedge clk);
    model_step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_eq("async_led", 32'(led), 32'd0);
    check_eq("async_ready", 32'(cfg_ready), 32'd0);
    check_eq("async_led3", 32'(led3), 32'd0);
    check_eq("async_ready3", 32'(cfg_ready3), 32'd0);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    repeat (24) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
